// File: rtl/shift_reg_n.sv
// Universal shift register (hold / shift right / shift left / parallel load) with synchronous clear,
// clock enable and a saturating shift counter. Optional macro ROTATE_EN adds a rot input for rotate shifts.
module shift_reg_n #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
`ifdef ROTATE_EN
    input  logic             rot,
`endif
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             zero
);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             right_in, left_in;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_ONE;
    endfunction

    // Rotation feeds the bit falling off the opposite end back in place of the serial input.
`ifdef ROTATE_EN
    assign right_in = rot ? q_q[0]       : sin_r;
    assign left_in  = rot ? q_q[WIDTH-1] : sin_l;
`else
    assign right_in = sin_r;
    assign left_in  = sin_l;
`endif

    always_comb begin
        q_d   = q_q;
        cnt_d = cnt_q;
        if (clr) begin
            q_d   = '0;
            cnt_d = '0;
        end else if (en) begin
            case (mode_e'(mode))
                MODE_SHR: begin
                    q_d   = {right_in, q_q[WIDTH-1:1]};
                    cnt_d = sat_inc(cnt_q);
                end
                MODE_SHL: begin
                    q_d   = {q_q[WIDTH-2:0], left_in};
                    cnt_d = sat_inc(cnt_q);
                end
                MODE_LOAD: begin
                    q_d   = d;
                    cnt_d = '0;
                end
                default: begin
                    q_d   = q_q;
                    cnt_d = cnt_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q   <= '0;
            cnt_q <= '0;
        end else begin
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end
    end

    assign q         = q_q;
    assign shift_cnt = cnt_q;
    assign sout_r    = q_q[0];
    assign sout_l    = q_q[WIDTH-1];
    assign zero      = (q_q == '0);

endmodule

// File: tb/tb_shift_reg_n.sv
// Directed self-checking bench for shift_reg_n (WIDTH=8, CNT_W=4); rotate steps run when ROTATE_EN is defined.
module tb_shift_reg_n;

    logic       clk = 1'b0;
    logic       reset;
    logic       clr;
    logic       en;
    logic [1:0] mode;
    logic       sin_r;
    logic       sin_l;
`ifdef ROTATE_EN
    logic       rot;
`endif
    logic [7:0] d;
    logic [7:0] q;
    logic       sout_r;
    logic       sout_l;
    logic [3:0] shift_cnt;
    logic       zero;

    int checks = 0;
    int errors = 0;

    shift_reg_n #(.WIDTH(8), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .en        (en),
        .mode      (mode),
        .sin_r     (sin_r),
        .sin_l     (sin_l),
`ifdef ROTATE_EN
        .rot       (rot),
`endif
        .d         (d),
        .q         (q),
        .sout_r    (sout_r),
        .sout_l    (sout_l),
        .shift_cnt (shift_cnt),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [7:0] eq, input logic [3:0] ecnt);
        chk({tag, ".q"},      32'(q),         32'(eq));
        chk({tag, ".cnt"},    32'(shift_cnt), 32'(ecnt));
        chk({tag, ".zero"},   32'(zero),      32'(eq == 8'h00));
        chk({tag, ".sout_r"}, 32'(sout_r),    32'(eq[0]));
        chk({tag, ".sout_l"}, 32'(sout_l),    32'(eq[7]));
    endtask

    initial begin
        reset = 1'b0; clr = 1'b0; en = 1'b0; mode = 2'b00;
        sin_r = 1'b0; sin_l = 1'b0; d = 8'h00;
`ifdef ROTATE_EN
        rot = 1'b0;
`endif
        tick(); tick();
        chk_state("reset", 8'h00, 4'd0);

        reset = 1'b1;
        tick();
        en = 1'b1; mode = 2'b11; d = 8'hA5;
        tick();
        chk_state("load_a5", 8'hA5, 4'd0);

        // Asynchronous reset mid-cycle clears without waiting for an edge.
        mode = 2'b00;
        #3 reset = 1'b0;
        #1 chk_state("async_rst", 8'h00, 4'd0);
        mode = 2'b11; d = 8'hFF;
        tick();
        chk_state("rst_held", 8'h00, 4'd0);
        reset = 1'b1;

        mode = 2'b11; d = 8'h96; sin_r = 1'b1; sin_l = 1'b1;
        tick();
        chk_state("load_96", 8'h96, 4'd0);
        mode = 2'b01; sin_r = 1'b1;
        tick();
        chk_state("shr_cb", 8'hCB, 4'd1);

        mode = 2'b00; sin_r = 1'b0;
        tick();
        chk_state("hold", 8'hCB, 4'd1);

        mode = 2'b11; d = 8'h81;
        tick();
        mode = 2'b10; sin_l = 1'b0;
        tick();
        chk_state("shl1", 8'h02, 4'd1);
        tick();
        chk_state("shl2", 8'h04, 4'd2);

        sin_l = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("sat.cnt", 32'(shift_cnt), (2 + i > 15) ? 32'd15 : 32'(2 + i));
        end
        chk_state("sat_end", 8'hFF, 4'd15);
        mode = 2'b11; d = 8'h00;
        tick();
        chk_state("load_0", 8'h00, 4'd0);

        d = 8'h3C;
        tick();
        mode = 2'b01; sin_r = 1'b0;
        tick();
        chk_state("shr_1e", 8'h1E, 4'd1);
        en = 1'b0; sin_r = 1'b1;
        tick(); tick(); tick();
        chk_state("en_off", 8'h1E, 4'd1);
        clr = 1'b1;
        tick();
        chk_state("clr_en0", 8'h00, 4'd0);
        en = 1'b1; mode = 2'b11; d = 8'hFF;
        tick();
        chk_state("clr_prio", 8'h00, 4'd0);
        clr = 1'b0;

        // Only the value present at the edge is captured.
        d = 8'hAA;
        #2 d = 8'h5A;
        tick();
        chk_state("edge_samp", 8'h5A, 4'd0);

`ifdef ROTATE_EN
        rot = 1'b1; sin_r = 1'b0; sin_l = 1'b0;
        mode = 2'b11; d = 8'h81;
        tick();
        mode = 2'b01;
        tick();
        chk_state("rotr", 8'hC0, 4'd1);
        mode = 2'b11;
        tick();
        mode = 2'b10;
        tick();
        chk_state("rotl", 8'h03, 4'd1);
        rot = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
